// File: rtl/scan_pkg.sv
// Shared types and the round-robin search for the scan slot scheduler.
// The top's NUM_SLOTS parameter defaults to NUM_SLOTS_DEF; the slot/mask types below are sized from it.
package scan_pkg;

  localparam int DIV_W_DEF     = 20;
  localparam int NUM_SLOTS_DEF = 4;
  localparam int SLOT_W        = (NUM_SLOTS_DEF > 1) ? $clog2(NUM_SLOTS_DEF) : 1;

  typedef logic [SLOT_W-1:0]        slot_t;
  typedef logic [NUM_SLOTS_DEF-1:0] mask_t;

  typedef enum logic {
    CFG_IDLE,
    CFG_PEND
  } cfg_state_e;

  // First enabled slot strictly after cur, wrapping; returns cur when only cur (or nothing) is enabled.
  function automatic slot_t next_slot(slot_t cur, mask_t m);
    slot_t nxt;
    slot_t cand;
    logic  found;
    nxt   = cur;
    found = 1'b0;
    for (int k = 1; k <= NUM_SLOTS_DEF; k++) begin
      cand = slot_t'((int'(cur) + k) % NUM_SLOTS_DEF);
      if (!found && m[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Clock-enable prescaler: counts 0..div-1 and emits a registered one-cycle tick after the last count.
// restart loads a new divisor and restarts the count at zero.
module scan_prescaler #(
  parameter int DIV_W       = 20,
  parameter int DEFAULT_DIV = 262144
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic [DIV_W-1:0] new_div,
  output logic             tick,
  output logic [DIV_W-1:0] div_cur
);

  logic [DIV_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             term;

  always_comb begin
    term      = (div_q <= DIV_W'(1)) || (pre_cnt_q >= (div_q - DIV_W'(1)));
    pre_cnt_d = pre_cnt_q;
    div_d     = div_q;
    tick_d    = tick_q;
    if (restart) begin
      div_d     = new_div;
      pre_cnt_d = '0;
      tick_d    = 1'b0;
    end else if (en) begin
      tick_d    = term;
      pre_cnt_d = term ? '0 : pre_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q <= '0;
      div_q     <= DIV_W'(DEFAULT_DIV);
      tick_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
    end
  end

  // A pending tick survives en=0 and reappears when en returns.
  assign tick    = tick_q & en;
  assign div_cur = div_q;

endmodule

// File: rtl/scan_slot_scheduler.sv
// Scan slot scheduler: prescaled round-robin slot pointer with a one-deep config handshake.
// Optional build macro SCAN_BLANK_EN adds anti-ghosting blanking of slot_onehot.
//
// state    | meaning
// CFG_IDLE | nothing pending, cfg_ready high
// CFG_PEND | config captured, applied on next tick (or next edge while en is low)
module scan_slot_scheduler
  import scan_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int NUM_SLOTS   = NUM_SLOTS_DEF,
  parameter int DEFAULT_DIV = 262144,
  parameter int BLANK_CYC   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         cfg_valid,
  input  logic [DIV_W-1:0]             cfg_div,
  input  logic [NUM_SLOTS-1:0]         cfg_mask,
  output logic                         cfg_ready,
  output logic                         tick,
  output logic [$clog2(NUM_SLOTS)-1:0] slot,
  output logic [NUM_SLOTS-1:0]         slot_onehot,
  output logic                         busy
);

  cfg_state_e       state_q, state_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  mask_t            pend_mask_q, pend_mask_d;
  mask_t            mask_q, mask_d;
  slot_t            slot_q, slot_d;
  logic             apply;
  logic             tick_en;
  logic [DIV_W-1:0] div_cur;
  logic             show;

  scan_prescaler #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .restart (apply),
    .new_div (pend_div_q),
    .tick    (tick_en),
    .div_cur (div_cur)
  );

  always_comb begin
    state_d     = state_q;
    pend_div_d  = pend_div_q;
    pend_mask_d = pend_mask_q;
    mask_d      = mask_q;
    slot_d      = slot_q;
    apply       = 1'b0;
    case (state_q)
      CFG_IDLE: begin
        if (cfg_valid) begin
          pend_div_d  = cfg_div;
          pend_mask_d = cfg_mask;
          state_d     = CFG_PEND;
        end
      end
      CFG_PEND: begin
        if (tick_en || !en) begin
          apply   = 1'b1;
          mask_d  = pend_mask_q;
          state_d = CFG_IDLE;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
    // The advance on an apply edge already sees the new mask.
    if (tick_en) slot_d = next_slot(slot_q, mask_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CFG_IDLE;
      pend_div_q  <= '0;
      pend_mask_q <= '0;
      mask_q      <= '1;
      slot_q      <= '0;
    end else begin
      state_q     <= state_d;
      pend_div_q  <= pend_div_d;
      pend_mask_q <= pend_mask_d;
      mask_q      <= mask_d;
      slot_q      <= slot_d;
    end
  end

`ifdef SCAN_BLANK_EN
  localparam int BLK_W = $clog2(BLANK_CYC + 1);
  logic [BLK_W-1:0] blank_q, blank_d;

  always_comb begin
    blank_d = blank_q;
    if (apply || (slot_d != slot_q)) blank_d = BLK_W'(BLANK_CYC);
    else if (blank_q != '0)          blank_d = blank_q - BLK_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blank_q <= '0;
    else       blank_q <= blank_d;
  end

  // A dwell no longer than the dead time would never show a slot, so keep the drivers off.
  assign show = (blank_q == '0) && (div_cur > DIV_W'(BLANK_CYC));
`else
  logic unused_blank;
  assign unused_blank = ^{div_cur, BLANK_CYC[0]};
  assign show         = 1'b1;
`endif

  assign cfg_ready   = (state_q == CFG_IDLE);
  assign busy        = (state_q == CFG_PEND);
  assign tick        = tick_en;
  assign slot        = slot_q;
  // Out-of-range slots shift past the top bit and decode to zero.
  assign slot_onehot = (show && (mask_q != '0)) ? (mask_t'(1) << slot_q) : '0;

endmodule

// File: tb/tb_scan_slot_scheduler.sv
// Directed bench for scan_slot_scheduler: cycle table for the main sequences, hand sequences for en/reset/blanking.
module tb_scan_slot_scheduler;

  localparam int DIV_W = 20;
  localparam int NS    = 4;
  localparam int NV    = 58;

  logic            clk       = 1'b0;
  logic            reset     = 1'b1;
  logic            en        = 1'b0;
  logic            cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_div  = '0;
  logic [NS-1:0]   cfg_mask  = '0;
  logic            cfg_ready;
  logic            tick;
  logic [1:0]      slot;
  logic [NS-1:0]   slot_onehot;
  logic            busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  scan_slot_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_div     (cfg_div),
    .cfg_mask    (cfg_mask),
    .cfg_ready   (cfg_ready),
    .tick        (tick),
    .slot        (slot),
    .slot_onehot (slot_onehot),
    .busy        (busy)
  );

  typedef struct {
    logic             en;
    logic             v;
    logic [DIV_W-1:0] div;
    logic [3:0]       mask;
    logic             t;
    logic [1:0]       s;
    logic [3:0]       oh;
    logic             r;
    logic             b;
  } vec_t;

  vec_t tbl[NV];

  function automatic vec_t mk(int e, int v, int d, int m, int t, int s, int oh, int rd, int b);
    vec_t x;
    x.en   = e[0];
    x.v    = v[0];
    x.div  = d[DIV_W-1:0];
    x.mask = m[3:0];
    x.t    = t[0];
    x.s    = s[1:0];
    x.oh   = oh[3:0];
    x.r    = rd[0];
    x.b    = b[0];
    return x;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_oh(string name, int exp);
`ifndef SCAN_BLANK_EN
    chk(name, int'(slot_onehot), exp);
`endif
  endtask

  task automatic wait_tick(string name, int max_cyc, int exp_n);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < max_cyc) begin
      @(negedge clk);
      n++;
      seen = tick;
    end
    if (!seen) n = -1;
    chk(name, n, exp_n);
  endtask

  initial begin
    // drive: en v div mask | expect: tick slot onehot ready busy (observed before driving)
    tbl[0]  = mk(0,1,4,'hF, 0,0,1,1,0);
    tbl[1]  = mk(0,0,4,'hF, 0,0,1,0,1);
    tbl[2]  = mk(1,0,4,'hF, 0,0,1,1,0);
    tbl[3]  = mk(1,0,4,'hF, 0,0,1,1,0);
    tbl[4]  = mk(1,0,4,'hF, 0,0,1,1,0);
    tbl[5]  = mk(1,0,4,'hF, 0,0,1,1,0);
    tbl[6]  = mk(1,0,4,'hF, 1,0,1,1,0);
    tbl[7]  = mk(1,0,4,'hF, 0,1,2,1,0);
    tbl[8]  = mk(1,0,4,'hF, 0,1,2,1,0);
    tbl[9]  = mk(1,0,4,'hF, 0,1,2,1,0);
    tbl[10] = mk(1,0,4,'hF, 1,1,2,1,0);
    tbl[11] = mk(1,0,4,'hF, 0,2,4,1,0);
    tbl[12] = mk(1,0,4,'hF, 0,2,4,1,0);
    tbl[13] = mk(1,0,4,'hF, 0,2,4,1,0);
    tbl[14] = mk(1,0,4,'hF, 1,2,4,1,0);
    tbl[15] = mk(1,0,4,'hF, 0,3,8,1,0);
    tbl[16] = mk(1,0,4,'hF, 0,3,8,1,0);
    tbl[17] = mk(1,0,4,'hF, 0,3,8,1,0);
    tbl[18] = mk(1,0,4,'hF, 1,3,8,1,0);
    tbl[19] = mk(1,1,4,'h5, 0,0,1,1,0);
    tbl[20] = mk(1,0,4,'h5, 0,0,1,0,1);
    tbl[21] = mk(1,0,4,'h5, 0,0,1,0,1);
    tbl[22] = mk(1,0,4,'h5, 1,0,1,0,1);
    tbl[23] = mk(1,0,4,'h5, 0,2,4,1,0);
    tbl[24] = mk(1,0,4,'h5, 0,2,4,1,0);
    tbl[25] = mk(1,0,4,'h5, 0,2,4,1,0);
    tbl[26] = mk(1,0,4,'h5, 0,2,4,1,0);
    tbl[27] = mk(1,0,4,'h5, 1,2,4,1,0);
    tbl[28] = mk(1,0,4,'h5, 0,0,1,1,0);
    tbl[29] = mk(1,0,4,'h5, 0,0,1,1,0);
    tbl[30] = mk(1,0,4,'h5, 0,0,1,1,0);
    tbl[31] = mk(1,0,4,'h5, 1,0,1,1,0);
    tbl[32] = mk(1,0,4,'h5, 0,2,4,1,0);
    tbl[33] = mk(1,1,0,'hF, 0,2,4,1,0);
    tbl[34] = mk(1,0,0,'hF, 0,2,4,0,1);
    tbl[35] = mk(1,0,0,'hF, 1,2,4,0,1);
    tbl[36] = mk(1,0,0,'hF, 0,3,8,1,0);
    tbl[37] = mk(1,0,0,'hF, 1,3,8,1,0);
    tbl[38] = mk(1,0,0,'hF, 1,0,1,1,0);
    tbl[39] = mk(1,1,1,'hF, 1,1,2,1,0);
    tbl[40] = mk(1,0,1,'hF, 1,2,4,0,1);
    tbl[41] = mk(1,0,1,'hF, 0,3,8,1,0);
    tbl[42] = mk(1,0,1,'hF, 1,3,8,1,0);
    tbl[43] = mk(1,1,2,'h0, 1,0,1,1,0);
    tbl[44] = mk(1,0,2,'h0, 1,1,2,0,1);
    tbl[45] = mk(1,0,2,'h0, 0,1,0,1,0);
    tbl[46] = mk(1,0,2,'h0, 0,1,0,1,0);
    tbl[47] = mk(1,0,2,'h0, 1,1,0,1,0);
    tbl[48] = mk(1,0,2,'h0, 0,1,0,1,0);
    tbl[49] = mk(1,1,2,'h8, 1,1,0,1,0);
    tbl[50] = mk(1,0,2,'h8, 0,1,0,0,1);
    tbl[51] = mk(1,0,2,'h8, 1,1,0,0,1);
    tbl[52] = mk(1,0,2,'h8, 0,3,8,1,0);
    tbl[53] = mk(1,0,2,'h8, 0,3,8,1,0);
    tbl[54] = mk(1,0,2,'h8, 1,3,8,1,0);
    tbl[55] = mk(1,1,8,'hF, 0,3,8,1,0);
    tbl[56] = mk(1,0,8,'hF, 1,3,8,0,1);
    tbl[57] = mk(1,0,8,'hF, 0,0,1,1,0);

    repeat (2) @(negedge clk);
    chk("reset tick", int'(tick), 0);
    chk("reset slot", int'(slot), 0);
    chk("reset onehot", int'(slot_onehot), 1);
    chk("reset ready", int'(cfg_ready), 1);
    chk("reset busy", int'(busy), 0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chk($sformatf("row%0d tick", i), int'(tick), int'(tbl[i].t));
      chk($sformatf("row%0d slot", i), int'(slot), int'(tbl[i].s));
      chk($sformatf("row%0d ready", i), int'(cfg_ready), int'(tbl[i].r));
      chk($sformatf("row%0d busy", i), int'(busy), int'(tbl[i].b));
      chk_oh($sformatf("row%0d onehot", i), int'(tbl[i].oh));
      en        = tbl[i].en;
      cfg_valid = tbl[i].v;
      cfg_div   = tbl[i].div;
      cfg_mask  = tbl[i].mask;
    end

    // en low for 10 edges with pre_cnt held at 2 of div 8
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("frozen%0d tick", i), int'(tick), 0);
      chk($sformatf("frozen%0d slot", i), int'(slot), 0);
    end
    en = 1'b1;
    wait_tick("resume tick latency", 20, 6);
    @(negedge clk);
    chk("resume slot", int'(slot), 1);
    chk_oh("resume onehot", 2);

    // config offered with en low applies on the following edge
    en        = 1'b0;
    cfg_valid = 1'b1;
    cfg_div   = DIV_W'(3);
    cfg_mask  = 4'b0011;
    @(negedge clk);
    chk("en0 cfg busy", int'(busy), 1);
    chk("en0 cfg ready", int'(cfg_ready), 0);
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("en0 apply busy", int'(busy), 0);
    chk("en0 apply ready", int'(cfg_ready), 1);
    chk("en0 apply slot", int'(slot), 1);
    en = 1'b1;
    wait_tick("div3 tick latency", 20, 3);
    @(negedge clk);
    chk("mask0011 slot", int'(slot), 0);
    chk_oh("mask0011 onehot", 1);

    // reset while a config is pending
    cfg_valid = 1'b1;
    cfg_div   = DIV_W'(5);
    cfg_mask  = 4'b0110;
    @(negedge clk);
    chk("pre-reset busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy", int'(busy), 0);
    chk("async reset ready", int'(cfg_ready), 1);
    chk("async reset slot", int'(slot), 0);
    chk("async reset onehot", int'(slot_onehot), 1);
    chk("async reset tick", int'(tick), 0);
    cfg_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("post-reset%0d tick", i), int'(tick), 0);
      chk($sformatf("post-reset%0d busy", i), int'(busy), 0);
    end

`ifdef SCAN_BLANK_EN
    en        = 1'b0;
    cfg_valid = 1'b1;
    cfg_div   = DIV_W'(8);
    cfg_mask  = 4'hF;
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    en = 1'b1;
    wait_tick("blank tick latency", 20, 8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("blank%0d onehot", i), int'(slot_onehot), 0);
    end
    @(negedge clk);
    chk("blank end onehot", int'(slot_onehot), 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
